// File: rtl/ram_ctl_if.sv
// Request/response bus between the LSU request path and ram_ctl.
// master drives requests and consumes responses; slave is the RAM side.
interface ram_ctl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ram_ctl.sv
// Single-port synchronous RAM with request/response handshake, hardware clear
// sequencer and out-of-range reporting. RAM_CTL_OUTREG_EN adds a response register stage.
module ram_ctl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 32768
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  ram_ctl_if.slave  bus,
  output logic      init_busy
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  cnt;
  logic              last_clear;
  logic              in_range;
  logic [IDX_W-1:0]  addr_idx;
  logic              accept;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wd;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              s1_valid;
  logic [DATA_W-1:0] s1_rdata;
  logic              s1_err;

  assign last_clear = (cnt == LAST_IDX);
  assign in_range   = ({1'b0, bus.req_addr} < DEPTH_X);
  assign addr_idx   = bus.req_addr[IDX_W-1:0];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_CLEAR;
    else      state <= state_nxt;
  end

  // Next-state logic; clr wins over the final clear step
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (!clr && last_clear) state_nxt = ST_RUN;
      ST_RUN:   if (clr)                state_nxt = ST_CLEAR;
      default:                          state_nxt = ST_CLEAR;
    endcase
  end

  // Output / datapath control decode
  always_comb begin
    bus.req_ready = 1'b0;
    init_busy     = 1'b0;
    accept        = 1'b0;
    mem_we        = 1'b0;
    mem_idx       = cnt;
    mem_wd        = '0;
    case (state)
      ST_CLEAR: begin
        init_busy = 1'b1;
        mem_we    = 1'b1;
      end
      ST_RUN: begin
        bus.req_ready = !clr;
        accept        = bus.req_valid && !clr;
        mem_we        = accept && bus.req_we && in_range;
        mem_idx       = addr_idx;
        mem_wd        = bus.req_wdata;
      end
      default: init_busy = 1'b1;
    endcase
  end

  // Clear counter: restarts on clr, parks at 0 outside CLEAR
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   cnt <= '0;
    else if (state == ST_RUN || clr || last_clear) cnt <= '0;
    else                                        cnt <= cnt + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wd;
  end

  // First response stage; rdata/err hold while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_rdata <= '0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_err   <= !in_range;
        s1_rdata <= (!bus.req_we && in_range) ? mem[addr_idx] : '0;
      end
    end
  end

`ifdef RAM_CTL_OUTREG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= s1_valid;
      if (s1_valid) begin
        bus.rsp_rdata <= s1_rdata;
        bus.rsp_err   <= s1_err;
      end
    end
  end
`else
  assign bus.rsp_valid = s1_valid;
  assign bus.rsp_rdata = s1_rdata;
  assign bus.rsp_err   = s1_err;
`endif

endmodule

// File: tb/tb_ram_ctl.sv
// Directed bench for ram_ctl at DEPTH=16, ADDR_W=8, DATA_W=8.
// Response latency follows RAM_CTL_OUTREG_EN.
module tb_ram_ctl;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 16;
`ifdef RAM_CTL_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic init_busy;

  ram_ctl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ram_ctl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .bus       (bus),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic          b_we   [16];
  logic [AW-1:0] b_addr [16];
  logic [DW-1:0] b_wd   [16];
  logic [DW-1:0] b_rd   [16];
  logic          b_err  [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive n back-to-back requests and check every cycle's response slot
  task automatic burst(input int n, input string tag);
    for (int e = 0; e < n + LAT + 1; e++) begin
      int j;
      if (e < n) begin
        bus.req_valid = 1'b1;
        bus.req_we    = b_we[e];
        bus.req_addr  = b_addr[e];
        bus.req_wdata = b_wd[e];
        chk({tag, "/ready"}, 32'(bus.req_ready), 32'd1);
      end else begin
        bus.req_valid = 1'b0;
      end
      tick();
      j = e - (LAT - 1);
      if (j >= 0 && j < n) begin
        chk({tag, "/valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "/rdata"}, 32'(bus.rsp_rdata), 32'(b_rd[j]));
        chk({tag, "/err"},   32'(bus.rsp_err),   32'(b_err[j]));
      end else begin
        chk({tag, "/idle"}, 32'(bus.rsp_valid), 32'd0);
      end
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_clear(input int start, input string tag);
    int n;
    n = start;
    while (bus.req_ready !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk({tag, "/cycles"}, 32'(n), 32'd16);
    chk({tag, "/busy"}, 32'(init_busy), 32'd0);
  endtask

  task automatic set_reads_zero(input int n);
    for (int i = 0; i < n; i++) begin
      b_we[i] = 1'b0; b_addr[i] = AW'(i); b_wd[i] = '0; b_rd[i] = '0; b_err[i] = 1'b0;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "/valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "/rdata"}, 32'(bus.rsp_rdata), 32'd0);
    chk({tag, "/err"},   32'(bus.rsp_err),   32'd0);
    chk({tag, "/busy"},  32'(init_busy),     32'd1);
    chk({tag, "/ready"}, 32'(bus.req_ready), 32'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    tick();
    tick();
    chk_reset("reset");

    rst = 1'b1;
    wait_clear(0, "init_clear");
    set_reads_zero(16);
    burst(16, "init_zero");

    b_we[0] = 1'b1; b_addr[0] = 8'd3; b_wd[0] = 8'hA5; b_rd[0] = 8'h00; b_err[0] = 1'b0;
    b_we[1] = 1'b0; b_addr[1] = 8'd3; b_wd[1] = 8'h00; b_rd[1] = 8'hA5; b_err[1] = 1'b0;
    burst(2, "raw3");

    b_we[0] = 1'b1; b_addr[0] = 8'd16; b_wd[0] = 8'h77; b_rd[0] = 8'h00; b_err[0] = 1'b1;
    b_we[1] = 1'b0; b_addr[1] = 8'd16; b_wd[1] = 8'h00; b_rd[1] = 8'h00; b_err[1] = 1'b1;
    b_we[2] = 1'b0; b_addr[2] = 8'd0;  b_wd[2] = 8'h00; b_rd[2] = 8'h00; b_err[2] = 1'b0;
    burst(3, "oor");

    for (int i = 0; i < 16; i++) begin
      b_we[i] = 1'b1; b_addr[i] = AW'(i); b_wd[i] = DW'(8'h10 + i); b_rd[i] = '0; b_err[i] = 1'b0;
    end
    burst(16, "fill");
    for (int i = 0; i < 16; i++) begin
      b_we[i] = 1'b0; b_rd[i] = DW'(8'h10 + i);
    end
    burst(16, "readback");

    tick();
    tick();
    chk("hold/valid", 32'(bus.rsp_valid), 32'd0);
    chk("hold/rdata", 32'(bus.rsp_rdata), 32'h1F);
    chk("hold/err",   32'(bus.rsp_err),   32'd0);

    // Read of addr 5 accepted, then clr blocks the next request
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 8'd5;
    tick();
    chk("clr_inflight/v0", 32'(bus.rsp_valid), 32'(LAT == 1));
    chk("clr_inflight/d0", 32'(bus.rsp_rdata), (LAT == 1) ? 32'h15 : 32'h1F);
    clr = 1'b1; bus.req_addr = 8'd6;
    #1;
    chk("clr_inflight/ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("clr_inflight/v1", 32'(bus.rsp_valid), 32'(LAT == 2));
    chk("clr_inflight/d1", 32'(bus.rsp_rdata), 32'h15);
    clr = 1'b0; bus.req_valid = 1'b0;
    chk("clr/busy", 32'(init_busy), 32'd1);
    wait_clear(0, "clr_clear");
    set_reads_zero(16);
    burst(16, "clr_zero");

    b_we[0] = 1'b1; b_addr[0] = 8'd2; b_wd[0] = 8'h5A; b_rd[0] = 8'h00; b_err[0] = 1'b0;
    b_we[1] = 1'b0; b_addr[1] = 8'd2; b_wd[1] = 8'h00; b_rd[1] = 8'h5A; b_err[1] = 1'b0;
    burst(2, "pre_rst");

    // Reset lands at clear cycle 7 and must restart the full sequence
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (7) tick();
    chk("midclear/busy", 32'(init_busy), 32'd1);
    rst = 1'b0;
    #1;
    chk_reset("rst_async");
    tick();
    chk_reset("rst_held");
    rst = 1'b1;
    wait_clear(0, "rst_clear");
    set_reads_zero(4);
    burst(4, "rst_zero");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ram_ctl.md
Name: ram_ctl

Overview:
- Parametrised single-port synchronous RAM with a request/response handshake, a hardware clear sequencer and out-of-range error reporting.
- It succeeds the fixed 8-bit x 32K load/store RAM in the LSU and sits behind the LSU request path.
- It generalises width and depth, returns a defined value instead of high-Z, and guarantees zeroed contents after reset without relying on simulation initial blocks.

Parameters:
- DATA_W, 8: data word width in bits.
- ADDR_W, 16: request address width in bits.
- DEPTH, 32768: number of words. Must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous request to re-run the clear sequence.
- req_valid  input  1  request present.
- req_ready  output  1  request can be accepted this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  response strobe, one cycle wide.
- rsp_rdata  output  DATA_W  read data.
- rsp_err  output  1  accepted request was out of range.
- init_busy  output  1  clear sequence in progress.

Behaviour:
- Reset values (rst low): FSM=CLEAR, clear counter=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_busy=1.
- FSM states: CLEAR and RUN.
- CLEAR state:
  - Writes 0 to word[counter] each cycle, then increments the counter.
  - After writing word DEPTH-1, moves to RUN on the next edge. CLEAR therefore lasts exactly DEPTH cycles after rst is released.
  - init_busy=1 and req_ready=0 throughout CLEAR.
- RUN state: init_busy=0; req_ready=1 unless clr is high.
- Accept condition: req_valid & req_ready at a rising edge.
- Accepted write, req_addr < DEPTH:
  - word[req_addr] <= req_wdata.
  - Next cycle: rsp_valid=1, rsp_err=0, rsp_rdata=0.
- Accepted read, req_addr < DEPTH:
  - Next cycle: rsp_valid=1, rsp_rdata=word[req_addr], rsp_err=0.
  - Read latency is 1 cycle.
- Accepted request with req_addr >= DEPTH (read or write):
  - Any write is dropped; memory is unchanged.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Idle cycles: rsp_valid=0. rsp_rdata and rsp_err hold their last values.
- Back-to-back requests: one accepted per cycle, no bubbles. A read at cycle N+1 of an address written at cycle N returns the new data.
- clr high in RUN:
  - Blocks acceptance that cycle; next state is CLEAR with counter=0.
  - A request accepted in the previous cycle still produces its response.
- clr high during CLEAR: counter restarts at 0, and the full DEPTH cycles are required again.
- rst asserted mid-clear or mid-transaction: everything returns to its reset values immediately. Any pending response is discarded.
- req_ready does not depend combinationally on req_valid.

Optional Feature:
- Macro: RAM_CTL_OUTREG_EN.
- Defined:
  - Adds one output register stage. rsp_valid, rsp_rdata and rsp_err appear 2 cycles after acceptance.
  - Throughput stays one request per cycle.
  - The extra stage also resets to 0.
  - Responses already in the pipeline when clr is asserted still emerge in order.
- Undefined: latency is 1 cycle as described above.

Test Plan (DEPTH=16, ADDR_W=8, DATA_W=8, macro undefined unless stated):
- Release rst -> init_busy=1 and req_ready=0 for exactly 16 cycles, then req_ready=1. Reads of addresses 0..15 all return 0x00 with rsp_err=0.
- Write 0xA5 to addr 3, then read addr 3 the next cycle -> write response rsp_valid=1, rsp_err=0; read response rsp_rdata=0xA5 exactly 1 cycle after its acceptance.
- Write 0x77 to addr 16, then read addr 16 -> both responses have rsp_err=1 and rsp_rdata=0x00. A follow-up read of addr 0 returns 0x00 (no aliasing).
- Fill addrs 0..15 with values 0x10+i, pulse clr for 1 cycle, wait -> req_ready=0 for 16 cycles, then all addrs read 0x00.
- Assert rst at clear cycle 7, release it -> clear restarts and takes a full 16 cycles. All outputs are 0 while rst is low.
- RAM_CTL_OUTREG_EN defined: issue 4 back-to-back reads of pre-written addrs 0..3 -> 4 consecutive rsp_valid pulses starting 2 cycles after the first acceptance, with data in request order.
